hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RISCV core; complements the forwarding controller.
//  Detects load-use hazards forwarding cannot cover and inserts one bubble.
//  Turns branch/JAL redirects into a FLUSH_CYCLES-long flush sequence.
//  Freezes the whole pipe while the data memory handshake is outstanding.
//  Keeps saturating stall/flush performance counters.
// PARAMETERS
//  FLUSH_CYCLES  2    cycles if_id_flush_op is held per redirect (>=1)
//  MEM_TIMEOUT   255  max MEM_WAIT cycles before mem_timeout_op (>=1)
//  CNT_WIDTH     32   width of perf counters
// PORTS
//  clk               in   1   core clock
//  reset             in   1   asynchronous, active-low reset
//  id_opcode_ip      in   7   opcode of instr in ID
//  id_rs1_ip         in   5   rs1 of instr in ID
//  id_rs2_ip         in   5   rs2 of instr in ID
//  idex_mem_read_ip  in   1   instr in ID/EX is a load
//  idex_dest_ip      in   5   rd of instr in ID/EX
//  ex_flush_req_ip   in   1   taken branch/JALR resolved in EX
//  dmem_req_ip       in   1   MEM stage issuing data-memory access
//  dmem_ack_ip       in   1   data memory completes access this cycle
//  perf_clr_ip       in   1   synchronous clear of both counters
//  pc_stall_op       out  1   hold PC
//  if_id_stall_op    out  1   hold IF/ID
//  id_ex_stall_op    out  1   hold ID/EX
//  ex_mem_stall_op   out  1   hold EX/MEM (MEM_WB receives bubble)
//  id_ex_bubble_op   out  1   load NOP into ID/EX
//  if_id_flush_op    out  1   squash IF/ID
//  id_ex_flush_op    out  1   squash ID/EX
//  mem_timeout_op    out  1   sticky error, cleared only by reset
//  stall_cnt_op      out  CNT_WIDTH  cycles with pc_stall_op=1
//  flush_cnt_op      out  CNT_WIDTH  redirects accepted
// BEHAVIOUR
//  Reset: state=RUN, counters/flags/pending=0, all outputs 0.
//  FSM states RUN, LOAD_STALL, FLUSH, MEM_WAIT. Outputs are combinational from state+inputs.
//  Priority, highest first: MEM_WAIT entry > redirect > load-use.
//  Operand use by opcode:
//   OP/BRANCH/STORE: rs1,rs2. OPIMM/LOAD/JALR: rs1. LUI/AUIPC/JAL: none.
//  load_use = idex_mem_read_ip & idex_dest_ip!=0 & (uses_rs1&rs1==dest | uses_rs2&rs2==dest).
//  RUN:
//   - dmem_req&!ack: freeze all 4 stall outs the same cycle, no bubble/flush.
//     Next state MEM_WAIT; timer=1.
//   - else ex_flush_req: if_id_flush=id_ex_flush=1; flush_cnt++.
//     FLUSH_CYCLES==1 stays RUN, else FLUSH with cnt=FLUSH_CYCLES-1.
//   - else id_opcode==JAL: if_id_flush=1 only (JAL itself proceeds); same counter/FSM rule.
//   - else load_use: pc_stall=if_id_stall=id_ex_bubble=1 -> LOAD_STALL.
//  LOAD_STALL: 1 cycle, outputs 0 (load now in MEM, forward from WB); -> RUN.
//   MEM_WAIT/redirect rules apply as in RUN.
//  FLUSH: if_id_flush=1; cnt-- each cycle; -> RUN when cnt reaches 0.
//   New ex_flush_req restarts cnt and re-asserts id_ex_flush (counted).
//  MEM_WAIT: all stalls=1; timer++.
//   - ack: release stalls the same cycle, then -> RUN.
//     If pend_flush set, go to FLUSH with cnt=FLUSH_CYCLES and clear pend_flush.
//   - timer==MEM_TIMEOUT w/o ack: set mem_timeout_op, -> RUN (drop access).
//   - ex_flush_req during MEM_WAIT: latch pend_flush (counted once).
//  stall_cnt++ every cycle pc_stall_op=1. Counters saturate at all-ones.
//  perf_clr wins over increment the same cycle.
//  Async reset mid-sequence: immediate return to reset values, pending flush discarded.
// STRUCTURE
//  CORE_PKG: add typedef enum logic[1:0] hazard_state_e {HZ_RUN,HZ_LOAD_STALL,HZ_FLUSH,HZ_MEM_WAIT}.
//   Reuse existing OPCODE_* constants.
//  Sub-module sat_counter #(W) (clk,reset,clr,inc,q): instantiated twice for the perf counters.
//  FSM + cnt/timer registers live in this module.
// TESTING
//  1 load x5 in ID/EX, ID=add x6,x5,x1 -> 1 cycle pc/if_id stall+bubble, then LOAD_STALL, stall_cnt=1.
//  2 load to x0 with ID using x0 -> no stall; OPIMM using rs2-field==dest -> no stall.
//  3 ex_flush_req with load_use same cycle, FLUSH_CYCLES=2 -> flushes asserted, no bubble.
//    if_id_flush high 2 cycles, flush_cnt=1.
//  4 dmem_req 4 cycles before ack, flush_req in cycle 2 -> stalls 4 cycles.
//    Then if_id_flush 2 cycles, flush_cnt=1.
//  5 MEM_TIMEOUT=3, no ack -> mem_timeout_op set after 3 wait cycles, sticky until reset.
//  6 reset low mid-FLUSH / saturate CNT_WIDTH=4 -> all outs 0 instantly; counter holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - pipeline sequencing states, RV32 opcodes and operand-use decode
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_LOAD_STALL,
    HZ_FLUSH,
    HZ_MEM_WAIT
  } hazard_state_e;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  // Returns {uses_rs2, uses_rs1}; formats without a register field never hazard on it.
  function automatic logic [1:0] rs_usage(input logic [6:0] opcode);
    logic [1:0] use_v;
    case (opcode)
      OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: use_v = 2'b11;
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: use_v = 2'b01;
      default:                                use_v = 2'b00;
    endcase
    return use_v;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// rtl/hazard_stall_ctrl_sat_counter.sv - saturating performance counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use bubble, redirect flush and data-memory freeze sequencer
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           id_opcode_ip,
  input  logic [4:0]           id_rs1_ip,
  input  logic [4:0]           id_rs2_ip,
  input  logic                 idex_mem_read_ip,
  input  logic [4:0]           idex_dest_ip,
  input  logic                 ex_flush_req_ip,
  input  logic                 dmem_req_ip,
  input  logic                 dmem_ack_ip,
  input  logic                 perf_clr_ip,
  output logic                 pc_stall_op,
  output logic                 if_id_stall_op,
  output logic                 id_ex_stall_op,
  output logic                 ex_mem_stall_op,
  output logic                 id_ex_bubble_op,
  output logic                 if_id_flush_op,
  output logic                 id_ex_flush_op,
  output logic                 mem_timeout_op,
  output logic [CNT_WIDTH-1:0] stall_cnt_op,
  output logic [CNT_WIDTH-1:0] flush_cnt_op
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int TMW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FCW-1:0] FC_FULL   = FCW'(FLUSH_CYCLES);
  localparam logic [FCW-1:0] FC_RELOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [TMW-1:0] TM_MAX    = TMW'(MEM_TIMEOUT);

  hazard_state_e  state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [TMW-1:0] timer_q, timer_d;
  logic           pend_q, pend_d;
  logic           tmo_q, tmo_d;

  logic [1:0] rs_use;
  logic       load_use;
  logic       mem_block;
  logic       is_jal;
  logic       redirect_req;
  logic       flush_acc;

  assign rs_use       = rs_usage(id_opcode_ip);
  assign load_use     = idex_mem_read_ip && (idex_dest_ip != 5'd0) &&
                        ((rs_use[0] && (id_rs1_ip == idex_dest_ip)) ||
                         (rs_use[1] && (id_rs2_ip == idex_dest_ip)));
  assign mem_block    = dmem_req_ip && !dmem_ack_ip;
  assign is_jal       = (id_opcode_ip == OPCODE_JAL);
  assign redirect_req = ex_flush_req_ip || is_jal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HZ_RUN;
      fcnt_q  <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    case (state_q)
      HZ_RUN, HZ_LOAD_STALL: begin
        if (mem_block) begin
          state_d = HZ_MEM_WAIT;
          timer_d = TMW'(1);
        end else if (redirect_req) begin
          state_d = (FLUSH_CYCLES == 1) ? HZ_RUN : HZ_FLUSH;
          fcnt_d  = FC_RELOAD;
        end else if ((state_q == HZ_RUN) && load_use) begin
          state_d = HZ_LOAD_STALL;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        if (ex_flush_req_ip) begin
          state_d = (FLUSH_CYCLES == 1) ? HZ_RUN : HZ_FLUSH;
          fcnt_d  = FC_RELOAD;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
          if (fcnt_q <= FCW'(1)) begin
            state_d = HZ_RUN;
          end
        end
      end
      HZ_MEM_WAIT: begin
        // A redirect seen while frozen is replayed as a full flush once memory answers.
        if (dmem_ack_ip) begin
          pend_d  = 1'b0;
          timer_d = '0;
          if (pend_q || ex_flush_req_ip) begin
            state_d = HZ_FLUSH;
            fcnt_d  = FC_FULL;
          end else begin
            state_d = HZ_RUN;
          end
        end else if (timer_q == TM_MAX) begin
          tmo_d   = 1'b1;
          pend_d  = 1'b0;
          timer_d = '0;
          state_d = HZ_RUN;
        end else begin
          timer_d = timer_q + TMW'(1);
          pend_d  = pend_q || ex_flush_req_ip;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    pc_stall_op     = 1'b0;
    if_id_stall_op  = 1'b0;
    id_ex_stall_op  = 1'b0;
    ex_mem_stall_op = 1'b0;
    id_ex_bubble_op = 1'b0;
    if_id_flush_op  = 1'b0;
    id_ex_flush_op  = 1'b0;
    flush_acc       = 1'b0;
    if (reset) begin
      case (state_q)
        HZ_RUN, HZ_LOAD_STALL: begin
          if (mem_block) begin
            pc_stall_op     = 1'b1;
            if_id_stall_op  = 1'b1;
            id_ex_stall_op  = 1'b1;
            ex_mem_stall_op = 1'b1;
          end else if (ex_flush_req_ip) begin
            if_id_flush_op = 1'b1;
            id_ex_flush_op = 1'b1;
            flush_acc      = 1'b1;
          end else if (is_jal) begin
            if_id_flush_op = 1'b1;
            flush_acc      = 1'b1;
          end else if ((state_q == HZ_RUN) && load_use) begin
            pc_stall_op     = 1'b1;
            if_id_stall_op  = 1'b1;
            id_ex_bubble_op = 1'b1;
          end
        end
        HZ_FLUSH: begin
          if_id_flush_op = 1'b1;
          id_ex_flush_op = ex_flush_req_ip;
          flush_acc      = ex_flush_req_ip;
        end
        HZ_MEM_WAIT: begin
          pc_stall_op     = !dmem_ack_ip;
          if_id_stall_op  = !dmem_ack_ip;
          id_ex_stall_op  = !dmem_ack_ip;
          ex_mem_stall_op = !dmem_ack_ip;
          flush_acc       = ex_flush_req_ip && !pend_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_timeout_op = tmo_q;

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr_ip),
    .inc   (pc_stall_op),
    .q     (stall_cnt_op)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr_ip),
    .inc   (flush_acc),
    .q     (flush_cnt_op)
  );

endmodule
